// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 codes, FSM state encoding and lane widths for the data-memory access path
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int LANE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / LANE_W;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the byte/halfword at offset from a read word and sign/zero extends it by funct3
//   funct3 : access size and sign
//   offset : byte address bits [1:0]
//   rdata  : raw memory word
//   data   : extended load result
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] data
);
    logic [LANE_W-1:0] b;
    logic [HALF_W-1:0] h;
    // Halfword offsets are always even here, so a byte-granular shift serves both sizes.
    assign b = LANE_W'(rdata >> {offset, 3'b000});
    assign h = HALF_W'(rdata >> {offset, 3'b000});
    always_comb
        data = (funct3 == F3_B)  ? {{(WORD_W-LANE_W){b[LANE_W-1]}}, b} :
               (funct3 == F3_H)  ? {{(WORD_W-HALF_W){h[HALF_W-1]}}, h} :
               (funct3 == F3_BU) ? {{(WORD_W-LANE_W){1'b0}}, b} :
               (funct3 == F3_HU) ? {{(WORD_W-HALF_W){1'b0}}, h} :
               rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store responder driving a wait-stated word memory over req/ack, stalling the core
//   iCLK/iRST_n                 : clock, synchronous active-low reset
//   iMemRead/iMemWrite/iFunct3  : request strobes and access type
//   iAddress/iWriteData         : byte address and right-justified store data
//   oReadData/oStall/oFault     : extended load result, core stall, fault pulse
//   oMemAddr/oMemWData/oMemBE   : word address, lane-shifted store data, byte enables
//   oMemReq/oMemWE              : memory request and write select
//   iMemRData/iMemAck           : memory read word and completion strobe
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic [2:0]        iFunct3,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [DATA_W-1:0] iWriteData,
    output logic [DATA_W-1:0] oReadData,
    output logic              oStall,
    output logic              oFault,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic [3:0]        oMemBE,
    output logic              oMemReq,
    output logic              oMemWE,
    input  logic [DATA_W-1:0] iMemRData,
    input  logic              iMemAck
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             rd_q;
    logic             req;
    logic             illegal;
    logic             misaligned;
    logic             go;
    logic [3:0]       be;
    logic [DATA_W-1:0] ext;
    assign req = iMemRead | iMemWrite;
    always_comb begin
        illegal    = (iMemRead & iMemWrite) |
                     (iMemRead & ((iFunct3 == 3'b011) | (iFunct3[2:1] == 2'b11))) |
                     (iMemWrite & (iFunct3 > F3_W));
        misaligned = ((iFunct3[1:0] == 2'b01) & iAddress[0]) |
                     ((iFunct3 == F3_W) & (iAddress[1:0] != 2'b00));
        be         = (iFunct3[1:0] == 2'b00) ? 4'b0001 << iAddress[1:0] :
                     (iFunct3[1:0] == 2'b01) ? 4'b0011 << {iAddress[1], 1'b0} :
                     4'b1111;
    end
    assign go = req & ~illegal & ~misaligned;
    // Stall rises in the launch cycle itself so the PC never advances past a pending access.
    assign oStall = iRST_n & ((state == ST_REQ) | ((state == ST_IDLE) & go));
    load_extend u_ext (
        .funct3 (f3_q),
        .offset (off_q),
        .rdata  (iMemRData),
        .data   (ext)
    );
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            rd_q      <= 1'b0;
            oReadData <= '0;
            oFault    <= 1'b0;
            oMemAddr  <= '0;
            oMemWData <= '0;
            oMemBE    <= '0;
            oMemReq   <= 1'b0;
            oMemWE    <= 1'b0;
        end else begin
            oFault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        oMemAddr  <= {iAddress[ADDR_W-1:2], 2'b00};
                        oMemWData <= iWriteData << {iAddress[1:0], 3'b000};
                        oMemBE    <= be;
                        oMemWE    <= iMemWrite;
                        oMemReq   <= 1'b1;
                        f3_q      <= iFunct3;
                        off_q     <= iAddress[1:0];
                        rd_q      <= iMemRead;
                        cnt       <= '0;
                        state     <= ST_REQ;
                    end else if (req) begin
                        oFault <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (iMemAck) begin
                        if (rd_q) oReadData <= ext;
                        oMemReq <= 1'b0;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        oFault  <= 1'b1;
                        oMemReq <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory responder for the core's control signals. It is the memory-side end of MemRead/MemWrite.
- Receives a load/store request from the datapath: read/write strobes, funct3, byte address and store data.
- Drives a word-organised, wait-stated data memory using a req/ack handshake.
- Stalls the core until the access completes.
- Returns sign- or zero-extended load data and flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width. Fixed at 32; other values are not supported.
- TIMEOUT, 15, maximum number of REQ cycles without ack before the access is aborted.

Ports:
- iCLK  in  1  core clock.
- iRST_n  in  1  synchronous reset, active-low.
- iMemRead  in  1  load request from the control unit.
- iMemWrite  in  1  store request from the control unit.
- iFunct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- iAddress  in  ADDR_W  byte address (ALU result).
- iWriteData  in  DATA_W  store data, rs2, right-justified.
- oReadData  out  DATA_W  extended load result, valid while state is DONE.
- oStall  out  1  holds PC and pipeline while an access is in flight.
- oFault  out  1  one-cycle pulse on a misaligned or illegal access.
- oMemAddr  out  ADDR_W  word address: iAddress with bits [1:0] forced to 0.
- oMemWData  out  DATA_W  store data shifted into the addressed byte lanes.
- oMemBE  out  4  byte enables.
- oMemReq  out  1  memory request.
- oMemWE  out  1  1 = write.
- iMemRData  in  DATA_W  memory read word.
- iMemAck  in  1  one-cycle completion strobe from memory.

Behaviour:
- Reset (iRST_n=0 at a rising edge): state IDLE; timeout counter 0.
  - Outputs after reset: oReadData=0, oMemReq=0, oMemWE=0, oMemBE=0, oMemAddr=0, oMemWData=0, oFault=0, oStall=0.
- State machine: IDLE -> REQ -> DONE -> IDLE.
- Validity check in IDLE, combinational:
  - Illegal if both iMemRead and iMemWrite are high.
  - Illegal if a load uses funct3 011, 110 or 111.
  - Illegal if a store uses funct3 011 or higher.
  - Misaligned if H/HU has addr[0]=1, or W has addr[1:0]!=0.
- IDLE, request valid:
  - oStall=1 combinationally in the same cycle.
  - Register oMemAddr, oMemWE, oMemBE and oMemWData; assert oMemReq; go to REQ.
- IDLE, request illegal or misaligned:
  - Register oFault=1 for one cycle; no memory request; oStall=0; stay in IDLE.
- REQ:
  - oStall=1; oMemReq and all memory outputs held stable.
  - Counter increments each cycle.
  - On iMemAck: for loads, capture the extended result into oReadData; deassert oMemReq; go to DONE.
  - If the counter reaches TIMEOUT with no ack: pulse oFault, deassert oMemReq, leave oReadData unchanged, go to DONE.
- DONE:
  - oStall=0, so the core retires the instruction this cycle.
  - iMemRead/iMemWrite are ignored; no relaunch; go to IDLE.
- Minimum access latency:
  - Ack in the first REQ cycle gives a stall of 2 cycles (IDLE + REQ).
  - Result is visible in DONE, the third cycle.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0], addr[1] only.
  - W: 1111.
- Store data: replicated or shifted into lanes, i.e. wdata << (8*addr[1:0]).
- Load extraction: select the byte or halfword at addr[1:0] from iMemRdata.
  - B/H: sign-extend from bit 7 or 15.
  - BU/HU: zero-extend.
  - W: pass through.
- Stores do not modify oReadData.
- iMemAck outside REQ is ignored.
- Reset mid-operation (REQ or DONE): the next edge gives IDLE and oMemReq=0. The pending access is abandoned; memory must tolerate a withdrawn request.
- oStall is never high while iRST_n=0.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding ST_IDLE, ST_REQ, ST_DONE.
  - Lane-width constants.
- One sub-module, load_extend: combinational byte/halfword select plus sign/zero extension from funct3, addr[1:0] and the read word. It is reused later by the multicycle core.

Test Plan:
- LW at 0x100, memory word 0xDEADBEEF, ack on first REQ cycle:
  - oMemAddr=0x100, oMemBE=1111, oStall high for 2 cycles.
  - oReadData=0xDEADBEEF in DONE.
- LB at 0x103, word 0x80FF_0000, ack after 3 wait cycles: oMemBE=1000, oReadData=0xFFFFFF80, stall 5 cycles.
  - Same access with LBU: oReadData=0x00000080.
- SH at 0x202, rs2=0x1234ABCD:
  - oMemAddr=0x200, oMemBE=1100, oMemWE=1, oMemWData[31:16]=0xABCD.
  - oReadData unchanged.
- LW at 0x101: oFault pulses 1 cycle, oMemReq never asserted, oStall stays 0.
  - Same for SH at 0x001, for both strobes high, and for a load with funct3=011.
- LW with no ack: oMemReq held TIMEOUT=15 cycles, then oFault pulse and DONE; oStall drops on the 17th cycle.
- iRST_n low during REQ of a SW: oMemReq=0 and state IDLE after the next edge.
  - A later LHU at 0x002 of word 0xFFEE0000 returns 0x0000FFEE.
